ma_stage: RTL and testbench
===========================

// Module: ma_stage
// PURPOSE
//   Memory-access (MA) stage of the data-driven pipeline; sits directly downstream of the FP/ALU stage.
//   Consumes the FP result packet plus its WRITE_EN/WRITE_DATA/LOAD_FLG side-band and performs the data-memory op:
//     STM -> write; LDM -> read and replace the result field; all-zero packets are absorbed; everything else passes through.
//   Single-entry registered stage with a Send/Ack handshake on both sides; owns an internal 2^ADDR_W x DATA_W data RAM.
// PARAMETERS
//   DATA_W   16   data/result field width (= FP DataL/DataR width)
//   HDR_W    22   header width {color,gen,dest,LR2,BR,CPY}, MSB-first
//   ADDR_W   8    data-RAM address width; depth = 2**ADDR_W
//   PKT_W    HDR_W+DATA_W+2   packet width; layout {HDR[PKT_W-1:DATA_W+2], C[DATA_W+1], RESULT[DATA_W:1], Z[0]}
// PORTS
//   CP          in   1       clock, rising edge
//   MR_n        in   1       reset, asynchronous, active-low
//   Send_in     in   1       upstream packet valid
//   Ack_out     out  1       upstream ready; transfer when Send_in & Ack_out at a CP rising edge
//   PACKET_IN   in   PKT_W   FP result packet
//   WRITE_EN    in   1       store request (STM)
//   WRITE_DATA  in   DATA_W  store address; low ADDR_W bits used
//   LOAD_FLG    in   1       load request (LDM); load address = PACKET_IN RESULT field, low ADDR_W bits
//   Send_out    out  1       downstream packet valid
//   Ack_in      in   1       downstream ready; transfer when Send_out & Ack_in at a CP rising edge
//   PACKET_OUT  out  PKT_W   registered output packet
// BEHAVIOUR
//   Reset (MR_n=0, async): state EMPTY; Send_out=0; Ack_out=0 while MR_n=0; PACKET_OUT=0. RAM contents are not reset.
//   States:
//     EMPTY  Ack_out=1, Send_out=0
//     LOAD   Ack_out=0, Send_out=0
//     FULL   Send_out=1, Ack_out=Ack_in
//   ACCEPT: a transfer in EMPTY, or in FULL with Ack_in=1; sampled fields are classified in priority order:
//     ABSORB  PACKET_IN==0 & WRITE_EN=0 & LOAD_FLG=0 -> packet dropped; next state EMPTY
//     STM     WRITE_EN=1 -> RAM[WRITE_DATA[ADDR_W-1:0]] <= RESULT at the accept edge; PACKET_OUT <= PACKET_IN; next FULL
//     LDM     LOAD_FLG=1 -> sync RAM read issued at addr RESULT[ADDR_W-1:0]; header, C, Z captured; next LOAD
//     other   PACKET_OUT <= PACKET_IN; next FULL
//     WRITE_EN=1 & LOAD_FLG=1 is illegal; STM takes priority and no read is issued.
//   LOAD -> FULL unconditionally, one cycle later: PACKET_OUT RESULT <= RAM read data; header, C, Z unchanged (no flag recompute).
//   FULL with Ack_in=1 and no new accept -> EMPTY. FULL with Ack_in=0 -> hold PACKET_OUT and Send_out stable.
//   Latency, accept edge to Send_out=1: 1 cycle pass/STM; 2 cycles LDM.
//   Throughput: 1 packet/cycle for pass/STM; each LDM inserts one bubble.
//   Ordering: strictly in order; at most one packet held, including LOAD.
//   RAW hazard: STM accepted at edge N is visible to an LDM accepted at edge N+1 or later (one accept per edge, so no same-edge conflict).
//   Address bits above ADDR_W are ignored (wrap); no error flag.
//   Reset mid-LOAD/FULL: held packet is discarded; any write already performed remains in RAM.
// TESTING
//   1 Reset: MR_n=0 mid-FULL -> Send_out=0, Ack_out=0, PACKET_OUT=0 immediately (no CP edge); after release, Ack_out=1.
//   2 Pass-through ADD: RESULT=0x1234, C=1, Z=0, Ack_in=1 -> PACKET_OUT identical on the next edge; Send_out high 1 cycle.
//   3 STM then LDM: STM WRITE_DATA=0x0105, RESULT=0xBEEF; next cycle LDM RESULT=0x0005
//     -> LDM output RESULT=0xBEEF (address wraps to 0x05), header/C/Z of the LDM packet preserved.
//   4 Absorb: PACKET_IN=0, WRITE_EN=0, LOAD_FLG=0 -> no Send_out; stage stays EMPTY; Ack_out stays 1.
//   5 Backpressure: Ack_in=0 for 5 cycles while FULL -> PACKET_OUT stable, Ack_out=0, next Send_in stalled;
//     raise Ack_in with Send_in=1 -> old packet out and new packet in on the same edge.
//   6 Stream of 4 packets {pass,LDM,pass,pass} with Ack_in=1 -> outputs in order, exactly one bubble after the LDM.

Source files
------------

// File: rtl/ma_stage.sv
// Purpose : memory-access stage; STM writes the data RAM, LDM replaces RESULT with RAM data, zero packets absorbed.
// Latency : accept edge to Send_out=1 is 1 cycle for pass/STM, 2 cycles for LDM (one bubble per LDM).
// Backpr. : single-entry stage; while FULL, Ack_out follows Ack_in so a packet enters as the held one leaves.
//
// Ports:
//   CP, MR_n              clock (rising edge), asynchronous active-low reset
//   Send_in / Ack_out     upstream handshake; transfer on Send_in & Ack_out at a CP edge
//   PACKET_IN             {HDR, C, RESULT, Z} from the FP/ALU stage
//   WRITE_EN, WRITE_DATA  store request and store address (low ADDR_W bits used)
//   LOAD_FLG              load request; load address is the RESULT field (low ADDR_W bits)
//   Send_out / Ack_in     downstream handshake; transfer on Send_out & Ack_in at a CP edge
//   PACKET_OUT            registered output packet
module ma_stage #(
    parameter int DATA_W = 16,
    parameter int HDR_W  = 22,
    parameter int ADDR_W = 8,
    parameter int PKT_W  = HDR_W + DATA_W + 2
) (
    input  logic              CP,
    input  logic              MR_n,
    input  logic              Send_in,
    output logic              Ack_out,
    input  logic [PKT_W-1:0]  PACKET_IN,
    input  logic              WRITE_EN,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic              LOAD_FLG,
    output logic              Send_out,
    input  logic              Ack_in,
    output logic [PKT_W-1:0]  PACKET_OUT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t             state_q, state_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic [DATA_W-1:0]  rd_dat_q;
    logic [DATA_W-1:0]  mem [0:DEPTH-1];

    logic               ack_int;
    logic               accept;
    logic               is_absorb;
    logic               is_ldm;
    logic               mem_we;
    logic               mem_re;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  wr_dat;

    // Upper store-address bits are deliberately ignored (address wraps).
    logic unused_wr_hi;
    assign unused_wr_hi = ^WRITE_DATA[DATA_W-1:ADDR_W];

    // Ready is forced low while reset is asserted, even though the state
    // register already sits in EMPTY.
    always_comb begin
        ack_int = 1'b0;
        unique case (state_q)
            ST_EMPTY: ack_int = 1'b1;
            ST_LOAD:  ack_int = 1'b0;
            ST_FULL:  ack_int = Ack_in;
            default:  ack_int = 1'b0;
        endcase
    end

    assign Ack_out    = MR_n & ack_int;
    assign Send_out   = (state_q == ST_FULL);
    assign PACKET_OUT = pkt_q;

    assign accept    = Send_in & Ack_out;
    assign is_absorb = (PACKET_IN == '0) & ~WRITE_EN & ~LOAD_FLG;
    // STM wins over LDM when both flags are raised; no read is issued then.
    assign is_ldm    = LOAD_FLG & ~WRITE_EN;

    assign mem_we  = accept & WRITE_EN;
    assign mem_re  = accept & is_ldm;
    assign wr_addr = WRITE_DATA[ADDR_W-1:0];
    assign wr_dat  = PACKET_IN[DATA_W:1];
    assign rd_addr = PACKET_IN[ADDR_W:1];

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;

        unique case (state_q)
            ST_EMPTY: ;
            // Read data arrives one edge after the LDM accept; only RESULT
            // is replaced, header and C/Z flags stay as captured.
            ST_LOAD: begin
                state_d            = ST_FULL;
                pkt_d[DATA_W:1]    = rd_dat_q;
            end
            ST_FULL: begin
                if (Ack_in) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // An accept can only occur in EMPTY or in FULL while the held packet
        // drains, so it overrides the drain decision above.
        if (accept) begin
            if (is_absorb) begin
                state_d = ST_EMPTY;
            end else if (is_ldm) begin
                state_d = ST_LOAD;
                pkt_d   = PACKET_IN;
            end else begin
                state_d = ST_FULL;
                pkt_d   = PACKET_IN;
            end
        end
    end

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= ST_EMPTY;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
        end
    end

    // Data RAM: not reset. Write and read share the accept edge but never in
    // the same cycle, so a store is visible to any later load.
    always_ff @(posedge CP) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_dat;
        end
        if (mem_re) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
module tb_ma_stage;

    localparam int DATA_W = 16;
    localparam int HDR_W  = 22;
    localparam int ADDR_W = 8;
    localparam int PKT_W  = HDR_W + DATA_W + 2;

    logic              CP;
    logic              MR_n;
    logic              Send_in;
    logic              Ack_out;
    logic [PKT_W-1:0]  PACKET_IN;
    logic              WRITE_EN;
    logic [DATA_W-1:0] WRITE_DATA;
    logic              LOAD_FLG;
    logic              Send_out;
    logic              Ack_in;
    logic [PKT_W-1:0]  PACKET_OUT;

    int n_cmp = 0;
    int n_bad = 0;

    ma_stage #(.DATA_W(DATA_W), .HDR_W(HDR_W), .ADDR_W(ADDR_W), .PKT_W(PKT_W)) dut (
        .CP(CP), .MR_n(MR_n),
        .Send_in(Send_in), .Ack_out(Ack_out), .PACKET_IN(PACKET_IN),
        .WRITE_EN(WRITE_EN), .WRITE_DATA(WRITE_DATA), .LOAD_FLG(LOAD_FLG),
        .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    function automatic logic [PKT_W-1:0] mk(input logic [HDR_W-1:0] h, input logic c,
                                            input logic [DATA_W-1:0] r, input logic z);
        return {h, c, r, z};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic idle_in();
        Send_in = 1'b0; PACKET_IN = '0; WRITE_EN = 1'b0; WRITE_DATA = '0; LOAD_FLG = 1'b0;
    endtask

    task automatic drive(input logic [PKT_W-1:0] p, input logic we, input logic [DATA_W-1:0] wd,
                         input logic lf);
        Send_in = 1'b1; PACKET_IN = p; WRITE_EN = we; WRITE_DATA = wd; LOAD_FLG = lf;
    endtask

    // Directed vectors, each applied to an empty stage with Ack_in=1.
    typedef struct {
        logic [PKT_W-1:0]  pkt;
        logic              we;
        logic [DATA_W-1:0] wd;
        logic              lf;
        int                lat;   // 0 = absorbed, else cycles to Send_out
        logic [PKT_W-1:0]  exp;
    } vec_t;

    // Transaction-level reference: one held slot, a RAM image, and a flag
    // saying whether the held LDM result is still one cycle from visible.
    logic [DATA_W-1:0] m_mem [0:255];
    bit                m_held;
    bit                m_pending;
    logic [PKT_W-1:0]  m_pkt;

    task automatic rstep(input logic s, input logic ack, input logic [PKT_W-1:0] p,
                         input logic we, input logic [DATA_W-1:0] wd, input logic lf,
                         output bit accepted);
        bit exp_send, exp_ack;
        Ack_in = ack;
        Send_in = s; PACKET_IN = p; WRITE_EN = we; WRITE_DATA = wd; LOAD_FLG = lf;
        #1;
        exp_send = m_held && !m_pending;
        exp_ack  = !m_held || (exp_send && ack);
        chk("rnd_send_out", 64'(Send_out), 64'(exp_send));
        chk("rnd_ack_out", 64'(Ack_out), 64'(exp_ack));
        if (exp_send) chk("rnd_packet_out", 64'(PACKET_OUT), 64'(m_pkt));
        accepted = s && exp_ack;
        if (exp_send && ack) m_held = 0;
        if (m_held && m_pending) m_pending = 0;
        if (accepted) begin
            if (p == '0 && !we && !lf) begin
                // dropped
            end else if (we) begin
                m_mem[wd % 256] = p[DATA_W:1];
                m_pkt = p; m_held = 1; m_pending = 0;
            end else if (lf) begin
                m_pkt = p;
                m_pkt[DATA_W:1] = m_mem[p[DATA_W:1] % 256];
                m_held = 1; m_pending = 1;
            end else begin
                m_pkt = p; m_held = 1; m_pending = 0;
            end
        end
        @(posedge CP);
        #1;
    endtask

    initial begin
        vec_t vecs[10];
        logic [PKT_W-1:0] pa, pb, stm_pkt, ldm_pkt;
        logic [PKT_W-1:0] stream[4];
        logic [PKT_W-1:0] expo[4];
        logic [PKT_W-1:0] got[4];
        int               got_cyc[4];
        int               n_got, n_sent;
        bit               acc;
        logic [63:0]      r64;

        // ---------------- reset state ----------------
        MR_n = 1'b0; Ack_in = 1'b1; idle_in();
        #3;
        chk("rst_send_out", 64'(Send_out), 64'd0);
        chk("rst_ack_out", 64'(Ack_out), 64'd0);
        chk("rst_packet_out", 64'(PACKET_OUT), 64'd0);
        #9 MR_n = 1'b1;
        tick();
        chk("post_rst_ack_out", 64'(Ack_out), 64'd1);

        // ---------------- table-driven single transactions ----------------
        vecs[0] = '{mk(22'h2ABCD, 1'b1, 16'h1234, 1'b0), 1'b0, 16'h0000, 1'b0, 1, mk(22'h2ABCD, 1'b1, 16'h1234, 1'b0)};
        vecs[1] = '{mk(22'h01111, 1'b0, 16'hBEEF, 1'b0), 1'b1, 16'h0105, 1'b0, 1, mk(22'h01111, 1'b0, 16'hBEEF, 1'b0)};
        vecs[2] = '{mk(22'h3F00F, 1'b1, 16'h0005, 1'b1), 1'b0, 16'h0000, 1'b1, 2, mk(22'h3F00F, 1'b1, 16'hBEEF, 1'b1)};
        vecs[3] = '{'0, 1'b0, 16'h0000, 1'b0, 0, '0};
        vecs[4] = '{mk(22'h00001, 1'b0, 16'h0F0F, 1'b1), 1'b1, 16'hABFF, 1'b0, 1, mk(22'h00001, 1'b0, 16'h0F0F, 1'b1)};
        vecs[5] = '{mk(22'h15555, 1'b0, 16'h77FF, 1'b0), 1'b0, 16'h0000, 1'b1, 2, mk(22'h15555, 1'b0, 16'h0F0F, 1'b0)};
        vecs[6] = '{mk(22'h0A0A0, 1'b1, 16'h00FF, 1'b0), 1'b1, 16'h0010, 1'b1, 1, mk(22'h0A0A0, 1'b1, 16'h00FF, 1'b0)};
        vecs[7] = '{mk(22'h12345, 1'b1, 16'h0010, 1'b1), 1'b0, 16'h0000, 1'b1, 2, mk(22'h12345, 1'b1, 16'h00FF, 1'b1)};
        vecs[8] = '{'0, 1'b1, 16'h0020, 1'b0, 1, '0};
        vecs[9] = '{mk(22'h2FFFF, 1'b0, 16'hFF20, 1'b1), 1'b0, 16'h0000, 1'b1, 2, mk(22'h2FFFF, 1'b0, 16'h0000, 1'b1)};

        for (int i = 0; i < 10; i++) begin
            Ack_in = 1'b1;
            drive(vecs[i].pkt, vecs[i].we, vecs[i].wd, vecs[i].lf);
            chk($sformatf("vec%0d_ack_before", i), 64'(Ack_out), 64'd1);
            tick();
            idle_in();
            for (int c = 1; c <= 2; c++) begin
                chk($sformatf("vec%0d_send_c%0d", i, c), 64'(Send_out), 64'(c == vecs[i].lat));
                if (c == vecs[i].lat)
                    chk($sformatf("vec%0d_packet", i), 64'(PACKET_OUT), 64'(vecs[i].exp));
                if (vecs[i].lat == 0)
                    chk($sformatf("vec%0d_ack_c%0d", i, c), 64'(Ack_out), 64'd1);
                tick();
            end
        end

        // ---------------- STM followed immediately by LDM ----------------
        stm_pkt = mk(22'h0C0DE, 1'b1, 16'hBEEF, 1'b0);
        ldm_pkt = mk(22'h1F00D, 1'b0, 16'h0005, 1'b1);
        drive(mk(22'h0C0DE, 1'b1, 16'h1111, 1'b0), 1'b1, 16'h0105, 1'b0);  // pre-load different data
        tick();
        drive(stm_pkt, 1'b1, 16'h0105, 1'b0);
        tick();
        drive(ldm_pkt, 1'b0, 16'h0000, 1'b1);
        chk("raw_stm_send", 64'(Send_out), 64'd1);
        chk("raw_stm_packet", 64'(PACKET_OUT), 64'(stm_pkt));
        chk("raw_ack_full", 64'(Ack_out), 64'd1);
        tick();
        idle_in();
        chk("raw_load_send", 64'(Send_out), 64'd0);
        chk("raw_load_ack", 64'(Ack_out), 64'd0);
        tick();
        chk("raw_ldm_send", 64'(Send_out), 64'd1);
        chk("raw_ldm_packet", 64'(PACKET_OUT), 64'(mk(22'h1F00D, 1'b0, 16'hBEEF, 1'b1)));
        tick();

        // ---------------- backpressure ----------------
        pa = mk(22'h2AAAA, 1'b0, 16'hAAAA, 1'b1);
        pb = mk(22'h15555, 1'b1, 16'h5555, 1'b0);
        Ack_in = 1'b0;
        drive(pa, 1'b0, 16'h0000, 1'b0);
        tick();
        drive(pb, 1'b0, 16'h0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_send", 64'(Send_out), 64'd1);
            chk("bp_packet_hold", 64'(PACKET_OUT), 64'(pa));
            chk("bp_ack_out", 64'(Ack_out), 64'd0);
            tick();
        end
        Ack_in = 1'b1;
        #1;
        chk("bp_release_ack", 64'(Ack_out), 64'd1);
        tick();
        idle_in();
        chk("bp_new_send", 64'(Send_out), 64'd1);
        chk("bp_new_packet", 64'(PACKET_OUT), 64'(pb));
        tick();

        // ---------------- stream {pass, LDM, pass, pass} ----------------
        stream[0] = mk(22'h00AA1, 1'b0, 16'h1001, 1'b0);
        stream[1] = mk(22'h00AA2, 1'b1, 16'h0105, 1'b1);   // LDM of addr 0x05
        stream[2] = mk(22'h00AA3, 1'b0, 16'h1003, 1'b1);
        stream[3] = mk(22'h00AA4, 1'b1, 16'h1004, 1'b0);
        expo[0] = stream[0];
        expo[1] = mk(22'h00AA2, 1'b1, 16'hBEEF, 1'b1);
        expo[2] = stream[2];
        expo[3] = stream[3];
        n_got = 0; n_sent = 0;
        Ack_in = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (Send_out && n_got < 4) begin
                got[n_got] = PACKET_OUT;
                got_cyc[n_got] = cyc;
                n_got++;
            end
            if (Ack_out && n_sent < 4) begin
                drive(stream[n_sent], 1'b0, 16'h0000, n_sent == 1);
                n_sent++;
            end else begin
                idle_in();
            end
            tick();
        end
        idle_in();
        chk("stream_count", 64'(n_got), 64'd4);
        for (int k = 0; k < 4 && k < n_got; k++)
            chk($sformatf("stream_pkt%0d", k), 64'(got[k]), 64'(expo[k]));
        if (n_got == 4) begin
            chk("stream_gap_ldm", 64'(got_cyc[1] - got_cyc[0]), 64'd2);
            chk("stream_gap_p3", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
            chk("stream_gap_p4", 64'(got_cyc[3] - got_cyc[2]), 64'd1);
        end

        // ---------------- async reset while FULL ----------------
        Ack_in = 1'b0;
        drive(mk(22'h3ABCD, 1'b1, 16'h4321, 1'b1), 1'b0, 16'h0000, 1'b0);
        tick();
        idle_in();
        chk("mid_full_send", 64'(Send_out), 64'd1);
        #2 MR_n = 1'b0;
        #1;
        chk("async_rst_send", 64'(Send_out), 64'd0);
        chk("async_rst_ack", 64'(Ack_out), 64'd0);
        chk("async_rst_packet", 64'(PACKET_OUT), 64'd0);
        #1 MR_n = 1'b1;
        #1;
        chk("async_rel_ack", 64'(Ack_out), 64'd1);
        tick();

        // ---------------- randomized against the reference ----------------
        m_held = 0; m_pending = 0; m_pkt = '0;
        for (int a = 0; a < 256; a++) begin
            acc = 0;
            for (int t = 0; t < 8 && !acc; t++) begin
                r64 = {$urandom(), $urandom()};
                rstep(1'b1, 1'b1, r64[PKT_W-1:0], 1'b1, {r64[63:56], 8'(a)}, 1'b0, acc);
            end
            if (!acc) chk("fill_accept_timeout", 64'd0, 64'd1);
        end
        for (int n = 0; n < 3000; n++) begin
            int   kind;
            logic s, ack, we, lf;
            logic [PKT_W-1:0]  p;
            logic [DATA_W-1:0] wd;
            r64  = {$urandom(), $urandom()};
            p    = r64[PKT_W-1:0];
            wd   = 16'($urandom());
            kind = $urandom_range(0, 10);
            s    = ($urandom_range(0, 9) < 7);
            ack  = ($urandom_range(0, 9) < 7);
            we   = 1'b0; lf = 1'b0;
            case (kind)
                0:          p = '0;
                1, 2, 3:    we = 1'b1;
                4, 5, 6:    lf = 1'b1;
                10:         begin we = 1'b1; lf = 1'b1; end
                default:    ;
            endcase
            rstep(s, ack, p, we, wd, lf, acc);
        end
        // drain
        for (int n = 0; n < 4; n++) rstep(1'b0, 1'b1, '0, 1'b0, '0, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
